// File: rtl/divider.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock,
// sharing the op_start/op_clear/op_done handshake of the Booth multiplier.
module divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             op_done,
    output logic             busy,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   d;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   q_sh;
    logic [WIDTH:0]     trial;

    // Shift {R,Q} left one bit and trial-subtract D with a (WIDTH+1)-bit two's-complement add.
    always_comb begin
        r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
        q_sh  = {q[WIDTH-2:0], 1'b0};
        trial = {1'b0, r_sh} + {1'b1, ~d} + (WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            op_done     <= 1'b0;
            busy        <= 1'b0;
        end else if (op_clear) begin
            state       <= IDLE;
            q           <= '0;
            r           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            op_done     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        d   <= divisor;
                        cnt <= '0;
                        if (divisor == '0) begin
                            // Divide by zero resolves in a single edge with a fixed result.
                            state       <= DONE;
                            q           <= '1;
                            r           <= dividend;
                            div_by_zero <= 1'b1;
                            op_done     <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            q           <= dividend;
                            r           <= '0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!trial[WIDTH]) begin
                        r <= trial[WIDTH-1:0];
                        q <= q_sh | WIDTH'(1);
                    end else begin
                        r <= r_sh;
                        q <= q_sh;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        op_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    op_done <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = q;
    assign remainder = r;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_divider;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset_n;
    logic             op_start;
    logic             op_clear;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             op_done;
    logic             busy;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int checks = 0;
    int errors = 0;

    divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .op_done     (op_done),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordinary integer division, with the fixed divide-by-zero result.
    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] eq, output logic [WIDTH-1:0] er,
                                    output logic ez);
        if (b == '0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
    endfunction

    // Pulse op_start for one edge (E0); returns #1 after E0.
    task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    // Counts edges after the current point until op_done; -1 when the budget expires.
    task automatic wait_done(output int n);
        n = 0;
        while (!op_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!op_done) n = -1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({op_done, busy, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset: done=%b busy=%b dbz=%b q=%h r=%h, expected all zero",
                     op_done, busy, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One full operation, checking latency, status flags and the result.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] eq, er;
        logic ez;
        int n, exp_n;
        ref_div(a, b, eq, er, ez);
        // Divide by zero finishes on E0; otherwise WIDTH iteration edges follow E0.
        exp_n = ez ? 0 : WIDTH;
        do_start(a, b);
        checks++;
        if (busy !== !ez) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected %b", name, busy, !ez);
        end
        wait_done(n);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s latency: got %0d edges after E0, expected %0d", name, n, exp_n);
        end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: a=%h b=%h got q=%h r=%h dbz=%b busy=%b expected q=%h r=%h dbz=%b",
                     name, a, b, quotient, remainder, div_by_zero, busy, eq, er, ez);
        end
        do_clear();
        checks++;
        if (op_done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL %s clear_after_done: done=%b q=%h r=%h expected 0",
                     name, op_done, quotient, remainder);
        end
    endtask

    task automatic test_basic();
        run_op("basic_100_7", 64'd100, 64'd7);
    endtask

    task automatic test_div_zero();
        run_op("div_zero", 64'h1234, 64'd0);
    endtask

    task automatic test_boundaries();
        run_op("max_by_1", '1, 64'd1);
        run_op("small_by_larger", 64'd5, 64'd9);
        run_op("msb_by_max", 64'h8000_0000_0000_0000, '1);
        run_op("max_by_max", '1, '1);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = {$urandom, $urandom};
            case (i % 5)
                0:       b = {$urandom, $urandom};
                1:       b = WIDTH'($urandom_range(1, 1000));
                2:       b = {32'd0, $urandom};
                3:       b = a >> $urandom_range(1, 60);
                default: b = (i == 9) ? '0 : {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            run_op("random", a, b);
        end
    endtask

    task automatic test_clear_abort();
        int n;
        do_start(64'd100, 64'd7);
        repeat (29) @(posedge clk);
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || op_done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL clear_abort: busy=%b done=%b q=%h r=%h expected all zero",
                     busy, op_done, quotient, remainder);
        end
        repeat (70) @(posedge clk);
        #1;
        checks++;
        if (op_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort_stays_idle: done=%b busy=%b expected 0 0", op_done, busy);
        end
        run_op("after_clear_81_9", 64'd81, 64'd9);
        n = 0;
    endtask

    task automatic test_start_with_clear();
        @(negedge clk);
        dividend = 64'd50;
        divisor  = 64'd3;
        op_start = 1'b1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || op_done !== 1'b0) begin
            errors++;
            $display("FAIL start_with_clear: busy=%b done=%b expected 0 0", busy, op_done);
        end
    endtask

    task automatic test_start_held();
        int n;
        @(negedge clk);
        dividend = 64'd20;
        divisor  = 64'd3;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n);
        checks++;
        if (n != WIDTH || quotient !== 64'd6 || remainder !== 64'd2) begin
            errors++;
            $display("FAIL start_held: edges=%0d q=%h r=%h expected edges=%0d q=6 r=2",
                     n, quotient, remainder, WIDTH);
        end
        @(negedge clk);
        dividend = 64'd99;
        divisor  = 64'd0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (op_done !== 1'b1 || busy !== 1'b0 || quotient !== 64'd6 || remainder !== 64'd2
            || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL start_held_done_hold: done=%b busy=%b q=%h r=%h dbz=%b expected 1 0 6 2 0",
                     op_done, busy, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        op_start = 1'b0;
        do_clear();
    endtask

    task automatic test_operand_change();
        int n;
        do_start(64'd1000, 64'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 64'd12345;
        divisor  = 64'd0;
        wait_done(n);
        checks++;
        if (n < 0 || quotient !== 64'd142 || remainder !== 64'd6 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL operand_change: edges=%0d q=%h r=%h dbz=%b expected q=142 r=6 dbz=0",
                     n, quotient, remainder, div_by_zero);
        end
        do_clear();
    endtask

    task automatic test_async_reset();
        do_start(64'd100, 64'd7);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (op_done !== 1'b0 || busy !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL async_reset: done=%b busy=%b q=%h r=%h expected all zero",
                     op_done, busy, quotient, remainder);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after_reset_100_7", 64'd100, 64'd7);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_random();
        test_clear_abort();
        test_start_with_clear();
        test_start_held();
        test_operand_change();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
